// File: rtl/wave_sweep_ctrl.sv
// rtl/wave_sweep_ctrl.sv - frequency-sweep scheduler driving the waveform generator freq and resetn
module wave_sweep_ctrl #(
    parameter int FREQ_WIDTH  = 13,
    parameter int DWELL_WIDTH = 16,
    parameter int MAX_FREQ    = 4095,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [FREQ_WIDTH-1:0]  cfg_start_freq,
    input  logic [FREQ_WIDTH-1:0]  cfg_stop_freq,
    input  logic [FREQ_WIDTH-1:0]  cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [1:0]             cfg_mode,
    input  logic                   start,
    input  logic                   abort,
    output logic [FREQ_WIDTH-1:0]  freq,
    output logic                   gen_resetn,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   sweep_count
);

    localparam logic [FREQ_WIDTH-1:0] MAX_F = FREQ_WIDTH'(MAX_FREQ);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_DWELL, S_STEP, S_DONE} state_t;

    state_t                 state;
    logic                   cfg_loaded;
    logic [FREQ_WIDTH-1:0]  start_r, stop_r, step_r;
    logic [DWELL_WIDTH-1:0] dwell_r, dwell_cnt;
    logic [1:0]             mode_r;
    logic [FREQ_WIDTH-1:0]  origin, target;
    logic                   dir_up;
    logic                   arm_cnt;
    logic [FREQ_WIDTH-1:0]  next_freq, pp_freq;

    function automatic logic [FREQ_WIDTH-1:0] clamp_max(input logic [FREQ_WIDTH-1:0] v);
        return (v > MAX_F) ? MAX_F : v;
    endfunction

    // One step from f toward tgt, never passing it; the sum carries an extra bit so it cannot wrap.
    function automatic logic [FREQ_WIDTH-1:0] step_toward(
        input logic [FREQ_WIDTH-1:0] f,
        input logic [FREQ_WIDTH-1:0] tgt,
        input logic [FREQ_WIDTH-1:0] stp,
        input logic                  up
    );
        logic [FREQ_WIDTH:0] sum;
        sum = {1'b0, f} + {1'b0, stp};
        if (up)
            return (sum > {1'b0, tgt}) ? tgt : sum[FREQ_WIDTH-1:0];
        else
            return ((f < stp) || ((f - stp) < tgt)) ? tgt : (f - stp);
    endfunction

    assign next_freq = step_toward(freq, target, step_r, dir_up);
    assign pp_freq   = step_toward(freq, origin, step_r, !dir_up);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cfg_loaded  <= 1'b0;
            cfg_ready   <= 1'b1;
            start_r     <= '0;
            stop_r      <= '0;
            step_r      <= '0;
            dwell_r     <= '0;
            mode_r      <= 2'b00;
            origin      <= '0;
            target      <= '0;
            dir_up      <= 1'b0;
            arm_cnt     <= 1'b0;
            dwell_cnt   <= '0;
            freq        <= '0;
            gen_resetn  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sweep_count <= '0;
        end else begin
            done <= 1'b0;
            if (cfg_valid && cfg_ready) begin
                start_r    <= clamp_max(cfg_start_freq);
                stop_r     <= clamp_max(cfg_stop_freq);
                step_r     <= (cfg_step == '0) ? FREQ_WIDTH'(1) : cfg_step;
                dwell_r    <= cfg_dwell;
                mode_r     <= (cfg_mode == 2'b11) ? 2'b00 : cfg_mode;
                cfg_loaded <= 1'b1;
            end
            if (abort) begin
                state      <= S_IDLE;
                freq       <= '0;
                gen_resetn <= 1'b0;
                busy       <= 1'b0;
                cfg_ready  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && cfg_loaded) begin
                            state       <= S_ARM;
                            freq        <= start_r;
                            sweep_count <= '0;
                            gen_resetn  <= 1'b0;
                            busy        <= 1'b1;
                            cfg_ready   <= 1'b0;
                            arm_cnt     <= 1'b0;
                            origin      <= start_r;
                            target      <= stop_r;
                            dir_up      <= (start_r <= stop_r);
                        end
                    end
                    S_ARM: begin
                        if (arm_cnt) begin
                            state      <= S_DWELL;
                            gen_resetn <= 1'b1;
                            dwell_cnt  <= '0;
                        end else begin
                            arm_cnt <= 1'b1;
                        end
                    end
                    S_DWELL: begin
                        if (dwell_cnt == dwell_r)
                            state <= S_STEP;
                        else
                            dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                    end
                    S_STEP: begin
                        dwell_cnt <= '0;
                        if (freq != target) begin
                            freq  <= next_freq;
                            state <= S_DWELL;
                        end else begin
                            case (mode_r)
                                2'b01: begin
                                    freq        <= start_r;
                                    sweep_count <= sweep_count + CNT_WIDTH'(1);
                                    state       <= S_DWELL;
                                end
                                2'b10: begin
                                    origin      <= target;
                                    target      <= origin;
                                    dir_up      <= !dir_up;
                                    freq        <= pp_freq;
                                    sweep_count <= sweep_count + CNT_WIDTH'(1);
                                    state       <= S_DWELL;
                                end
                                default: begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            endcase
                        end
                    end
                    S_DONE: begin
                        state     <= S_IDLE;
                        cfg_ready <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// tb/tb_wave_sweep_ctrl.sv - directed self-checking bench for wave_sweep_ctrl
module tb_wave_sweep_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [12:0] cfg_start_freq = '0;
    logic [12:0] cfg_stop_freq = '0;
    logic [12:0] cfg_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic [1:0]  cfg_mode = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] freq;
    logic        gen_resetn;
    logic        busy;
    logic        done;
    logic [7:0]  sweep_count;

    int checks = 0;
    int errors = 0;

    logic [12:0] tf [0:63];
    logic        tg [0:63];
    logic        tb_ [0:63];
    logic        td [0:63];
    logic [7:0]  tc [0:63];
    int          done_cnt;

    wave_sweep_ctrl dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start_freq(cfg_start_freq), .cfg_stop_freq(cfg_stop_freq),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
        .start(start), .abort(abort),
        .freq(freq), .gen_resetn(gen_resetn), .busy(busy), .done(done),
        .sweep_count(sweep_count)
    );

    always #5 clock = ~clock;

    task automatic load_cfg(input int s, input int e, input int st, input int d, input int m);
        @(negedge clock);
        cfg_start_freq = 13'(s); cfg_stop_freq = 13'(e); cfg_step = 13'(st);
        cfg_dwell = 16'(d); cfg_mode = 2'(m); cfg_valid = 1'b1;
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    // Pulse start, then sample n cycles; k=1 is the first cycle after the start edge.
    task automatic run_trace(input int n, input bit inject);
        done_cnt = 0;
        @(negedge clock);
        start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            start = 1'b0;
            tf[k] = freq; tg[k] = gen_resetn; tb_[k] = busy; td[k] = done; tc[k] = sweep_count;
            if (done) done_cnt++;
            if (inject && k == 2) cfg_valid = 1'b1;
            if (inject && k == 3) cfg_valid = 1'b0;
        end
    endtask

    task automatic do_abort();
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (freq !== 13'd0) begin errors++; $display("FAIL rst_freq got %0d exp 0", freq); end
        checks++; if (gen_resetn !== 1'b0) begin errors++; $display("FAIL rst_genrn got %0b exp 0", gen_resetn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", cfg_ready); end
        checks++; if (sweep_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", sweep_count); end
        run_trace(3, 1'b0);
        checks++; if (tb_[2] !== 1'b0) begin errors++; $display("FAIL noconfig_busy got %0b exp 0", tb_[2]); end
        checks++; if (tg[3] !== 1'b0) begin errors++; $display("FAIL noconfig_genrn got %0b exp 0", tg[3]); end
    endtask

    task automatic test_basic_up();
        load_cfg(100, 400, 100, 3, 0);
        run_trace(28, 1'b0);
        checks++; if (tg[1] !== 1'b0 || tg[2] !== 1'b0) begin errors++; $display("FAIL up_arm_genrn got %0b%0b exp 00", tg[1], tg[2]); end
        checks++; if (tg[3] !== 1'b1) begin errors++; $display("FAIL up_genrn_rel got %0b exp 1", tg[3]); end
        checks++; if (tf[1] !== 13'd100 || tf[7] !== 13'd100) begin errors++; $display("FAIL up_p0 got %0d/%0d exp 100", tf[1], tf[7]); end
        checks++; if (tf[8] !== 13'd200 || tf[12] !== 13'd200) begin errors++; $display("FAIL up_p1 got %0d/%0d exp 200", tf[8], tf[12]); end
        checks++; if (tf[13] !== 13'd300 || tf[17] !== 13'd300) begin errors++; $display("FAIL up_p2 got %0d/%0d exp 300", tf[13], tf[17]); end
        checks++; if (tf[18] !== 13'd400 || tf[22] !== 13'd400) begin errors++; $display("FAIL up_p3 got %0d/%0d exp 400", tf[18], tf[22]); end
        checks++; if (td[23] !== 1'b1 || done_cnt != 1) begin errors++; $display("FAIL up_done got %0b cnt %0d exp 1 cnt 1", td[23], done_cnt); end
        checks++; if (tb_[22] !== 1'b1 || tb_[23] !== 1'b0) begin errors++; $display("FAIL up_busy got %0b%0b exp 10", tb_[22], tb_[23]); end
        checks++; if (tf[28] !== 13'd400 || tg[28] !== 1'b1) begin errors++; $display("FAIL up_hold got %0d/%0b exp 400/1", tf[28], tg[28]); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL up_ready got %0b exp 1", cfg_ready); end
    endtask

    task automatic test_overshoot();
        load_cfg(100, 350, 100, 3, 0);
        run_trace(24, 1'b0);
        checks++; if (tf[13] !== 13'd300) begin errors++; $display("FAIL clamp_p2 got %0d exp 300", tf[13]); end
        checks++; if (tf[18] !== 13'd350) begin errors++; $display("FAIL clamp_p3 got %0d exp 350", tf[18]); end
        checks++; if (td[23] !== 1'b1 || done_cnt != 1) begin errors++; $display("FAIL clamp_done got %0b cnt %0d exp 1 cnt 1", td[23], done_cnt); end
    endtask

    task automatic test_pingpong();
        load_cfg(500, 300, 100, 0, 2);
        run_trace(14, 1'b0);
        checks++; if (tf[3] !== 13'd500) begin errors++; $display("FAIL pp_k3 got %0d exp 500", tf[3]); end
        checks++; if (tf[5] !== 13'd400) begin errors++; $display("FAIL pp_k5 got %0d exp 400", tf[5]); end
        checks++; if (tf[7] !== 13'd300) begin errors++; $display("FAIL pp_k7 got %0d exp 300", tf[7]); end
        checks++; if (tf[9] !== 13'd400) begin errors++; $display("FAIL pp_k9 got %0d exp 400", tf[9]); end
        checks++; if (tf[11] !== 13'd500) begin errors++; $display("FAIL pp_k11 got %0d exp 500", tf[11]); end
        checks++; if (tf[13] !== 13'd400) begin errors++; $display("FAIL pp_k13 got %0d exp 400", tf[13]); end
        checks++; if (tc[8] !== 8'd0 || tc[9] !== 8'd1) begin errors++; $display("FAIL pp_cnt1 got %0d/%0d exp 0/1", tc[8], tc[9]); end
        checks++; if (tc[12] !== 8'd1 || tc[13] !== 8'd2) begin errors++; $display("FAIL pp_cnt2 got %0d/%0d exp 1/2", tc[12], tc[13]); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL pp_nodone got %0d exp 0", done_cnt); end
        do_abort();
        checks++; if (freq !== 13'd0 || gen_resetn !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pp_abort got %0d/%0b/%0b exp 0/0/0", freq, gen_resetn, busy); end
    endtask

    task automatic test_cfg_gating();
        cfg_start_freq = 13'd5000; cfg_stop_freq = 13'd4093; cfg_step = 13'd0; cfg_dwell = 16'd0; cfg_mode = 2'd3;
        load_cfg(5000, 4093, 0, 0, 3);
        cfg_start_freq = 13'd100; cfg_stop_freq = 13'd100; cfg_step = 13'd7; cfg_dwell = 16'd9; cfg_mode = 2'd1;
        run_trace(12, 1'b1);
        checks++; if (tf[1] !== 13'd4095) begin errors++; $display("FAIL gate_clamp got %0d exp 4095", tf[1]); end
        checks++; if (tf[5] !== 13'd4094 || tf[7] !== 13'd4093) begin errors++; $display("FAIL gate_step1 got %0d/%0d exp 4094/4093", tf[5], tf[7]); end
        checks++; if (td[9] !== 1'b1 || done_cnt != 1) begin errors++; $display("FAIL gate_done got %0b cnt %0d exp 1 cnt 1", td[9], done_cnt); end
        run_trace(12, 1'b0);
        checks++; if (tf[1] !== 13'd4095 || tf[5] !== 13'd4094) begin errors++; $display("FAIL gate_keep got %0d/%0d exp 4095/4094", tf[1], tf[5]); end
        checks++; if (td[9] !== 1'b1) begin errors++; $display("FAIL gate_keep_done got %0b exp 1", td[9]); end
    endtask

    task automatic test_abort();
        load_cfg(100, 400, 100, 3, 0);
        run_trace(4, 1'b0);
        do_abort();
        checks++; if (freq !== 13'd0 || gen_resetn !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ab_dwell got %0d/%0b/%0b exp 0/0/0", freq, gen_resetn, busy); end
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        checks++; if (done_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL ab_nodone got %0d/%0b exp 0/0", done_cnt, busy); end
        @(negedge clock);
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || gen_resetn !== 1'b0 || freq !== 13'd0) begin errors++; $display("FAIL ab_start got %0b/%0b/%0d exp 0/0/0", busy, gen_resetn, freq); end
        load_cfg(200, 200, 1, 2, 1);
        run_trace(16, 1'b0);
        checks++; if (tc[6] !== 8'd0 || tc[7] !== 8'd1) begin errors++; $display("FAIL rep_cnt1 got %0d/%0d exp 0/1", tc[6], tc[7]); end
        checks++; if (tc[10] !== 8'd1 || tc[11] !== 8'd2) begin errors++; $display("FAIL rep_cnt2 got %0d/%0d exp 1/2", tc[10], tc[11]); end
        checks++; if (tc[15] !== 8'd3) begin errors++; $display("FAIL rep_cnt3 got %0d exp 3", tc[15]); end
        checks++; if (tf[9] !== 13'd200 || done_cnt != 0) begin errors++; $display("FAIL rep_freq got %0d done %0d exp 200 done 0", tf[9], done_cnt); end
        do_abort();
    endtask

    task automatic test_async_reset();
        load_cfg(100, 400, 100, 3, 0);
        run_trace(8, 1'b0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (freq !== 13'd0 || gen_resetn !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_out got %0d/%0b/%0b exp 0/0/0", freq, gen_resetn, busy); end
        checks++; if (cfg_ready !== 1'b1 || sweep_count !== 8'd0 || done !== 1'b0) begin errors++; $display("FAIL ar_out2 got %0b/%0d/%0b exp 1/0/0", cfg_ready, sweep_count, done); end
        @(negedge clock);
        reset = 1'b0;
        run_trace(3, 1'b0);
        checks++; if (tb_[2] !== 1'b0 || tg[3] !== 1'b0) begin errors++; $display("FAIL ar_noload got %0b/%0b exp 0/0", tb_[2], tg[3]); end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic_up();
        test_overshoot();
        test_pingpong();
        test_cfg_gating();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_sweep_ctrl.md
Name: wave_sweep_ctrl

Overview:
Frequency-sweep scheduler for the 12-bit angle/triangle/square waveform generator. It captures a sweep configuration through a valid/ready handshake and steps the generator's freq input from a start value to a stop value, holding each step for a programmable dwell. It also owns the generator's active-low reset, and supports single, repeat and ping-pong sweeps.

Parameters:
FREQ_WIDTH, 13, width of the generator freq input and all frequency fields
DWELL_WIDTH, 16, width of the dwell counter and cfg_dwell
MAX_FREQ, 4095, largest legal freq; keeps the generator's CNT-(freq<<5) terminal count positive for CNT=131072
CNT_WIDTH, 8, width of sweep_count

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_valid  input  1  config offer
cfg_ready  output  1  high only in IDLE
cfg_start_freq  input  FREQ_WIDTH  first frequency of sweep
cfg_stop_freq  input  FREQ_WIDTH  last frequency of sweep
cfg_step  input  FREQ_WIDTH  frequency increment magnitude
cfg_dwell  input  DWELL_WIDTH  dwell length; hold is cfg_dwell+1 cycles
cfg_mode  input  2  00 single, 01 repeat, 10 ping-pong, 11 treated as 00
start  input  1  begin sweep (IDLE only)
abort  input  1  terminate sweep
freq  output  FREQ_WIDTH  drives generator freq
gen_resetn  output  1  drives generator resetn
busy  output  1  high in ARM/DWELL/STEP
done  output  1  one-cycle pulse at sweep completion
sweep_count  output  CNT_WIDTH  completed end-points in repeat/ping-pong, wraps modulo 2^CNT_WIDTH

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All state is cleared asynchronously.
- Reset values: freq=0, gen_resetn=0, busy=0, done=0, cfg_ready=1, sweep_count=0, state=IDLE, cfg_loaded=0.
- Config capture: occurs on cfg_valid&&cfg_ready.
  - start/stop are clamped to MAX_FREQ.
  - step=0 is stored as 1.
  - mode 11 is stored as 00.
  - cfg_loaded is set to 1.
  - cfg_valid outside IDLE is ignored. No capture takes place and the config registers are unchanged.
- Direction: dir_up = (start <= stop), latched at start.
- FSM states: IDLE, ARM, DWELL, STEP, DONE.
- IDLE:
  - start&&cfg_loaded&&!abort -> ARM. On that edge freq<=start_freq, sweep_count<=0 and gen_resetn<=0.
  - start without a loaded config is ignored.
- ARM: lasts exactly 2 cycles with gen_resetn=0, so the generator's freq register settles. It then goes to DWELL with gen_resetn<=1.
- DWELL: the counter runs 0..cfg_dwell, i.e. cfg_dwell+1 cycles, then -> STEP.
- STEP: 1 cycle. The frequency visible to the generator is therefore held for cfg_dwell+2 cycles per point.
  - If freq != target:
    - Up: next = freq+step, computed at FREQ_WIDTH+1 bits, clamped to target if greater.
    - Down: next = freq-step, clamped to target if freq<step or the result is below target.
    - freq<=next, then -> DWELL.
  - If freq == target (end-point reached):
    - mode 00 -> DONE.
    - mode 01 -> freq<=start_freq, sweep_count++, -> DWELL.
    - mode 10 -> swap origin/target, invert dir, sweep_count++, freq<=first step toward new target (clamped), -> DWELL.
- start == stop: a single point; the first STEP is an end-point.
- DONE: done=1 for this cycle only, busy=0, -> IDLE. freq holds its last value and gen_resetn stays 1 until the next start or abort.
- abort: in any non-IDLE state, or in DONE, the next state is IDLE with freq<=0, gen_resetn<=0 and no done pulse.
  - abort in IDLE forces freq=0 and gen_resetn=0.
  - abort has priority over start in the same cycle.
- cfg_loaded persists across sweeps; it is cleared only by reset.
- Registered outputs: all outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Basic up-sweep: load start=100, stop=400, step=100, dwell=3, mode 00, then pulse start -> gen_resetn low 2 cycles; freq=100,200,300,400, each held 5 cycles; one done pulse; busy low after DONE; freq stays 400.
- Overshoot clamp: start=100, stop=350, step=100 -> freq sequence 100,200,300,350, then done.
- Ping-pong down: start=500, stop=300, step=100, dwell=0, mode 10 -> 500,400,300,400,500,400,…; sweep_count increments at 300 and at 500; no done; abort -> freq=0, gen_resetn=0 next cycle.
- Config clamping and gating:
  - start=5000, step=0 captured as 4095 and 1.
  - cfg_valid while busy is ignored (config unchanged).
  - start before any config -> stays IDLE.
- Abort corners:
  - abort mid-DWELL -> IDLE next cycle with no done.
  - start&&abort together in IDLE -> stays IDLE.
  - mode 01 with start=stop=200 -> sweep_count increments every 2+dwell cycles.
- Async reset mid-sweep: assert reset between edges -> all outputs at reset values immediately; after release, start without a new config is ignored.
